// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC-driven synchronous memory read into a valid/ready instruction register
module instr_fetch #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_adv,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] pend_pc;
  logic              handshake;

  assign handshake = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_adv    = 1'b0;
    case (state)
      IDLE: if (fetch_en) state_nxt = REQ;
      REQ: begin
        pc_adv    = 1'b1;
        state_nxt = RESP;
      end
      RESP: state_nxt = HOLD;
      HOLD: if (handshake) state_nxt = fetch_en ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      pc_adv    = 1'b0;
    end
  end

  // Memory is not reset; the registered read gives read-before-write on a same-address program load.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
    if (state == REQ) begin
      rd_data <= mem[pc];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_pc <= '0;
    end else if (state == REQ) begin
      pend_pc <= pc;
    end
  end

  // Flush only drops valid; the last word and its PC remain visible but are no longer qualified.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end else begin
      case (state)
        RESP: begin
          instr       <= rd_data;
          instr_pc    <= pend_pc;
          instr_valid <= 1'b1;
        end
        HOLD: if (handshake) instr_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized and directed scoreboard bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [4:0]  pc;
  logic        pc_adv;
  logic        fetch_en;
  logic        flush;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic [15:0] instr;
  logic [4:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  instr_fetch #(.ADDR_W(5), .DATA_W(16), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_adv(pc_adv), .fetch_en(fetch_en),
    .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program memory, upstream PC counter, and outstanding fetches.
  logic [15:0] mem_m [32];
  logic [15:0] exp_instr_q [$];
  logic [4:0]  exp_pc_q [$];
  logic [4:0]  pc_nxt = '0;
  logic        pc_set_req = 1'b0;
  logic [4:0]  pc_set_val = '0;
  logic        mon_on = 1'b0;
  logic        prev_expect = 1'b0;
  logic        prev_valid = 1'b0;
  int          cyc = 0;
  int          adv_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      check("pc_adv", {31'd0, pc_adv}, {31'd0, prev_expect && !flush});
      if (instr_valid && !prev_valid) begin
        check("valid_outstanding", {31'd0, exp_instr_q.size() != 0}, 32'd1);
        check("latency", cyc - adv_cyc, 32'd2);
      end
      if (instr_valid && instr_ready && !rst && !flush) begin
        if (exp_instr_q.size() == 0) begin
          check("handshake_outstanding", 32'd0, 32'd1);
        end else begin
          check("sb_instr", {16'd0, instr}, {16'd0, exp_instr_q[0]});
          check("sb_instr_pc", {27'd0, instr_pc}, {27'd0, exp_pc_q[0]});
          void'(exp_instr_q.pop_front());
          void'(exp_pc_q.pop_front());
        end
      end
    end
    // Any flush or reset discards everything held or in flight.
    if (rst || flush) begin
      exp_instr_q.delete();
      exp_pc_q.delete();
    end else if (pc_adv === 1'b1) begin
      exp_instr_q.push_back(mem_m[pc]);
      exp_pc_q.push_back(pc);
      adv_cyc = cyc;
    end
    if (prog_we) mem_m[prog_addr] = prog_data;
    prev_expect = !rst && !flush && fetch_en && (exp_instr_q.size() == 0);
    prev_valid  = instr_valid;
    if (rst) begin
      pc_nxt = '0;
    end else if (pc_set_req) begin
      pc_nxt     = pc_set_val;
      pc_set_req = 1'b0;
    end else if (pc_adv === 1'b1) begin
      pc_nxt = pc + 5'd1;
    end
  end

  initial begin
    pc = '0;
    forever begin
      @(posedge clk);
      #1 pc = pc_nxt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (instr_valid) break;
    end
    if (!instr_valid) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic set_pc(input logic [4:0] v);
    pc_set_val = v;
    pc_set_req = 1'b1;
    step();
    step();
  endtask

  logic [15:0] held;
  int n;

  initial begin
    rst = 1'b1; fetch_en = 1'b0; flush = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; instr_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_instr", {16'd0, instr}, 32'd0);
    check("rst_instr_pc", {27'd0, instr_pc}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc_adv", {31'd0, pc_adv}, 32'd0);
    step();
    rst = 1'b0;
    mon_on = 1'b1;

    // Program load of every word so model and memory agree everywhere.
    for (int i = 0; i < 32; i++) begin
      prog_we   = 1'b1;
      prog_addr = 5'(i);
      prog_data = (i == 0) ? 16'h1234 : (i == 1) ? 16'hABCD : 16'($urandom);
      step();
    end
    prog_we = 1'b0;
    step();

    fetch_en = 1'b1; instr_ready = 1'b1;
    wait_valid("first", n);
    check("first_latency", n, 32'd4);
    check("first_instr", {16'd0, instr}, 32'h1234);
    check("first_pc", {27'd0, instr_pc}, 32'd0);
    wait_valid("second", n);
    check("second_gap", n, 32'd3);
    check("second_instr", {16'd0, instr}, 32'hABCD);
    check("second_pc", {27'd0, instr_pc}, 32'd1);

    step();
    instr_ready = 1'b0;
    wait_valid("bp", n);
    check("bp_instr", {16'd0, instr}, {16'd0, mem_m[2]});
    held = instr;
    repeat (5) begin
      @(negedge clk);
      check("bp_stable", {16'd0, instr}, {16'd0, held});
      check("bp_valid", {31'd0, instr_valid}, 32'd1);
      check("bp_no_adv", {31'd0, pc_adv}, 32'd0);
    end
    step();
    instr_ready = 1'b1;
    step();
    fetch_en = 1'b0;
    repeat (6) step();

    prog_we = 1'b1; prog_addr = 5'd31; prog_data = 16'h0F0F;
    step();
    prog_addr = 5'd0; prog_data = 16'h1234;
    step();
    prog_we = 1'b0;
    set_pc(5'd31);
    fetch_en = 1'b1;
    wait_valid("wrap31", n);
    check("wrap31_instr", {16'd0, instr}, 32'h0F0F);
    check("wrap31_pc", {27'd0, instr_pc}, 32'd31);
    wait_valid("wrap0", n);
    check("wrap0_instr", {16'd0, instr}, 32'h1234);
    check("wrap0_pc", {27'd0, instr_pc}, 32'd0);
    step();
    fetch_en = 1'b0;
    repeat (6) step();

    fetch_en = 1'b1;
    step();
    flush = 1'b1; fetch_en = 1'b0;
    @(negedge clk);
    check("flush_req_adv", {31'd0, pc_adv}, 32'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_req_idle_valid", {31'd0, instr_valid}, 32'd0);
    check("flush_req_idle_adv", {31'd0, pc_adv}, 32'd0);
    step();
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("flush_resp_noval", {31'd0, instr_valid}, 32'd0);
    end

    step();
    set_pc(5'd0);
    fetch_en = 1'b1;
    step();
    prog_we = 1'b1; prog_addr = pc; prog_data = 16'h5555; fetch_en = 1'b0;
    step();
    prog_we = 1'b0;
    wait_valid("rbw_old", n);
    check("rbw_old", {16'd0, instr}, 32'h1234);
    step();
    instr_ready = 1'b0;
    set_pc(5'd0);
    fetch_en = 1'b1;
    wait_valid("rbw_new", n);
    check("rbw_new", {16'd0, instr}, 32'h5555);
    check("rbw_new_pc", {27'd0, instr_pc}, 32'd0);
    step();
    fetch_en = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_hold_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_hold_instr", {16'd0, instr}, 32'd0);
    check("rst_hold_pc", {27'd0, instr_pc}, 32'd0);

    repeat (800) begin
      step();
      fetch_en    = ($urandom % 4) != 0;
      instr_ready = ($urandom % 5) < 3;
      prog_we     = ($urandom % 5) == 0;
      prog_addr   = 5'($urandom);
      prog_data   = 16'($urandom);
      flush       = ($urandom % 40) == 0;
    end
    step();
    flush = 1'b0; prog_we = 1'b0; fetch_en = 1'b0; instr_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    check("drain_empty", exp_instr_q.size(), 32'd0);
    check("drain_valid", {31'd0, instr_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
